// File: rtl/sha256_sched_pkg.sv
// Shared types and sizes for the SHA-256 core scheduler.
//   state_t   : scheduler FSM states
//   WORD_W    : width of one core bus word
//   BLOCK_W   : message block width (sixteen words)
//   DIGEST_W  : digest width (eight words)
//   WORDS_IN  : words streamed into the core per block
//   WORDS_OUT : digest words read back from the core
package sha256_sched_pkg;

  localparam int WORD_W    = 32;
  localparam int WORDS_IN  = 16;
  localparam int WORDS_OUT = 8;
  localparam int BLOCK_W   = WORD_W * WORDS_IN;
  localparam int DIGEST_W  = WORD_W * WORDS_OUT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_READ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sha256_sched_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester request levels
//   upd      : advance the pointer (asserted once per finished transaction)
//   upd_idx  : index of the requester that was just served
//   any      : at least one request present
//   win      : index of the winning requester
// The pointer names the requester that wins a tie; it moves only when a
// transaction finishes, so a grant cannot change under an active requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       any,
  output logic       win
);

  logic ptr;

  always_comb begin
    any = |req;
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ptr;
      default: win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (upd) begin
      ptr <= ~upd_idx;
    end
  end

endmodule

// File: rtl/sha256_sched.sv
// Shares one SHA-256 core between two hash clients.
//   TIMEOUT        : WAIT cycles tolerated before aborting with err
//   clk, rst       : clock, asynchronous active-high reset
//   req            : per-requester request levels (held until done)
//   blk0, blk1     : 512-bit message blocks, word 0 in [511:480]
//   gnt            : one-hot grant, high for the whole transaction
//   done           : one-cycle completion pulse to the served requester
//   err            : with done, 1 = core never signalled end of computation
//   digest         : H0 in [255:224] .. H7 in [31:0]
//   core_soc       : start-of-computation, high for the whole transaction
//   core_rd        : digest read strobe
//   core_data_out  : message word onto the shared core bus
//   core_data_oe   : drive enable for the shared core bus
//   core_eoc       : end-of-computation from the core
//   core_hash      : digest word currently presented by the core
module sha256_sched
  import sha256_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [BLOCK_W-1:0]  blk0,
  input  logic [BLOCK_W-1:0]  blk1,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                err,
  output logic [DIGEST_W-1:0] digest,
  output logic                core_soc,
  output logic                core_rd,
  output logic [WORD_W-1:0]   core_data_out,
  output logic                core_data_oe,
  input  logic                core_eoc,
  input  logic [WORD_W-1:0]   core_hash
);

  // One counter serves LOAD (0..15), WAIT (0..TIMEOUT) and READ (0..7).
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               idx;
  logic [BLOCK_W-1:0] blk_q;
  logic [BLOCK_W-1:0] sel_blk;
  logic               arb_any;
  logic               arb_win;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .upd     (state == ST_DONE),
    .upd_idx (idx),
    .any     (arb_any),
    .win     (arb_win)
  );

  assign sel_blk = arb_win ? blk1 : blk0;

  // Block copy kept pre-shifted by one word: word 0 goes straight from the
  // requester's input onto the bus at the grant edge, so the top word of
  // blk_q is always the word to drive next.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && arb_any) begin
      blk_q <= {sel_blk[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
    end else if (state == ST_LOAD) begin
      blk_q <= {blk_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      idx           <= 1'b0;
      gnt           <= 2'b00;
      done          <= 2'b00;
      err           <= 1'b0;
      digest        <= '0;
      core_soc      <= 1'b0;
      core_rd       <= 1'b0;
      core_data_out <= '0;
      core_data_oe  <= 1'b0;
    end else begin
      case (state)
        // IDLE: grant and present word 0 on the same edge.
        ST_IDLE: begin
          cnt <= '0;
          if (arb_any) begin
            idx           <= arb_win;
            gnt           <= arb_win ? 2'b10 : 2'b01;
            core_soc      <= 1'b1;
            core_data_oe  <= 1'b1;
            core_data_out <= sel_blk[BLOCK_W-1 -: WORD_W];
            state         <= ST_LOAD;
          end
        end
        // LOAD: one message word per cycle.
        ST_LOAD: begin
          if (cnt == CNT_W'(WORDS_IN - 1)) begin
            cnt           <= '0;
            core_data_oe  <= 1'b0;
            core_data_out <= '0;
            state         <= ST_WAIT;
          end else begin
            cnt           <= cnt + 1'b1;
            core_data_out <= blk_q[BLOCK_W-1 -: WORD_W];
          end
        end
        // WAIT: eoc takes priority over the timeout in the same cycle.
        ST_WAIT: begin
          if (core_eoc) begin
            cnt     <= '0;
            core_rd <= 1'b1;
            state   <= ST_READ;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            cnt      <= '0;
            core_soc <= 1'b0;
            gnt      <= 2'b00;
            done     <= gnt;
            err      <= 1'b1;
            digest   <= '0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // READ: the core walks its own address, so words arrive H0 first
        // and are shifted in from the bottom.
        ST_READ: begin
          digest <= {digest[DIGEST_W-WORD_W-1:0], core_hash};
          if (cnt == CNT_W'(WORDS_OUT - 1)) begin
            cnt      <= '0;
            core_rd  <= 1'b0;
            core_soc <= 1'b0;
            gnt      <= 2'b00;
            done     <= gnt;
            err      <= 1'b0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // DONE: single-cycle pulse; arbiter pointer advances this cycle.
        ST_DONE: begin
          done  <= 2'b00;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_sched.sv
module tb_sha256_sched;

  localparam int TO = 20;

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [511:0] blk0;
  logic [511:0] blk1;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         err;
  logic [255:0] digest;
  logic         core_soc;
  logic         core_rd;
  logic [31:0]  core_data_out;
  logic         core_data_oe;
  logic         core_eoc;
  logic [31:0]  core_hash;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_sched #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .blk0          (blk0),
    .blk1          (blk1),
    .gnt           (gnt),
    .done          (done),
    .err           (err),
    .digest        (digest),
    .core_soc      (core_soc),
    .core_rd       (core_rd),
    .core_data_out (core_data_out),
    .core_data_oe  (core_data_oe),
    .core_eoc      (core_eoc),
    .core_hash     (core_hash)
  );

  // Core model: records streamed words, raises eoc eoc_dly cycles into WAIT,
  // then presents a known digest one word per read strobe.
  logic [31:0]  mw [16];
  int           ld_n = 0;
  int           wcnt = 0;
  int           eoc_dly = -1;
  logic [2:0]   addr = 3'd0;
  logic         m_eoc;
  logic         f_eoc = 1'b0;
  logic [255:0] hsel;

  always @(posedge clk) begin
    if (!core_soc) begin
      ld_n <= 0;
      wcnt <= 0;
      addr <= 3'd0;
    end else begin
      if (core_data_oe && ld_n < 16) begin
        mw[ld_n] <= core_data_out;
        ld_n     <= ld_n + 1;
      end
      if (!core_data_oe && ld_n == 16) wcnt <= wcnt + 1;
      if (core_rd) addr <= addr + 3'd1;
    end
  end

  always_comb begin
    m_eoc = core_soc && !core_data_oe && (ld_n == 16) && (eoc_dly >= 0) && (wcnt == eoc_dly);
    hsel = 256'h0;
    if (mw[0] == 32'h61626380) hsel = DIG_ABC;
    else if (mw[0] == 32'h80000000) hsel = DIG_EMPTY;
    core_hash = hsel[255 - 32 * int'(addr) -: 32];
  end

  assign core_eoc = m_eoc | f_eoc;

  typedef struct {
    logic [1:0]   req;
    int           dly;
    logic [1:0]   gnt;
    logic         err;
    logic [255:0] dig;
    logic [511:0] blk;
    logic         drop;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string nm, input logic [1:0] exp_g, output int g);
    int k;
    k = 0;
    while (gnt == 2'b00 && k < 20) begin
      step();
      k++;
    end
    check($sformatf("%s gnt", nm), 512'(gnt), 512'(exp_g));
    g = cyc;
  endtask

  function automatic logic [511:0] loaded();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[511 - 32 * i -: 32] = mw[i];
    return v;
  endfunction

  task automatic run_txn(input string nm, input vec_t v);
    int g;
    int d;
    int exp_lat;
    req = v.req;
    eoc_dly = v.dly;
    wait_gnt(nm, v.gnt, g);
    d = -1;
    for (int i = 0; i < 200; i++) begin
      if (v.drop && cyc == g + 4) req = 2'b00;
      if (done != 2'b00) begin
        d = cyc;
        break;
      end
      step();
    end
    exp_lat = (v.dly < 0) ? TO + 17 : v.dly + 25;
    check($sformatf("%s done", nm), 512'(done), 512'(v.gnt));
    check($sformatf("%s latency", nm), 512'(d - g), 512'(exp_lat));
    check($sformatf("%s err", nm), 512'(err), 512'(v.err));
    check($sformatf("%s digest", nm), 512'(digest), 512'(v.dig));
    check($sformatf("%s gnt_in_done", nm), 512'(gnt), 512'(0));
    check($sformatf("%s load_words", nm), loaded(), v.blk);
    step();
    check($sformatf("%s done_pulse", nm), 512'(done), 512'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int first_rd;
    int ndone;
    blk0 = BLK_ABC;
    blk1 = BLK_EMPTY;

    vecs[0] = '{2'b11,  2, 2'b01, 1'b0, DIG_ABC,   BLK_ABC,   1'b0};
    vecs[1] = '{2'b11,  5, 2'b10, 1'b0, DIG_EMPTY, BLK_EMPTY, 1'b0};
    vecs[2] = '{2'b11,  0, 2'b01, 1'b0, DIG_ABC,   BLK_ABC,   1'b0};
    vecs[3] = '{2'b11,  1, 2'b10, 1'b0, DIG_EMPTY, BLK_EMPTY, 1'b0};
    vecs[4] = '{2'b01, -1, 2'b01, 1'b1, 256'h0,    BLK_ABC,   1'b0};
    vecs[5] = '{2'b01,  4, 2'b01, 1'b0, DIG_ABC,   BLK_ABC,   1'b0};
    vecs[6] = '{2'b10,  2, 2'b10, 1'b0, DIG_EMPTY, BLK_EMPTY, 1'b1};
    vecs[7] = '{2'b01,  7, 2'b01, 1'b0, DIG_ABC,   BLK_ABC,   1'b1};

    // reset state
    #1 rst = 1'b1;
    repeat (3) step();
    check("reset outputs",
          512'({gnt, done, err, core_soc, core_rd, core_data_oe, core_data_out, digest}), 512'(0));
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);
    req = 2'b00;
    step();
    check("idle after drop", 512'({gnt, core_soc}), 512'(0));

    // spurious eoc during LOAD
    req = 2'b01;
    eoc_dly = 3;
    wait_gnt("spur", 2'b01, g);
    repeat (5) step();
    f_eoc = 1'b1;
    step();
    step();
    f_eoc = 1'b0;
    check("spur still_loading", 512'(core_data_oe), 512'(1));
    first_rd = -1;
    for (int i = 0; i < 100; i++) begin
      if (core_rd && first_rd < 0) first_rd = cyc;
      if (done != 2'b00) break;
      step();
    end
    check("spur first_rd", 512'(first_rd - g), 512'(20));
    check("spur digest", 512'(digest), 512'(DIG_ABC));
    req = 2'b00;
    step();

    // reset asserted during READ word 3
    req = 2'b01;
    eoc_dly = 2;
    wait_gnt("rstmid", 2'b01, g);
    repeat (22) step();
    check("rstmid in_read", 512'(core_rd), 512'(1));
    #2 rst = 1'b1;
    #1;
    check("rstmid outputs",
          512'({gnt, done, err, core_soc, core_rd, core_data_oe, core_data_out, digest}), 512'(0));
    req = 2'b00;
    step();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done != 2'b00) ndone++;
      step();
    end
    check("rstmid no_done", 512'(ndone), 512'(0));
    run_txn("after_rst", '{2'b10, 1, 2'b10, 1'b0, DIG_EMPTY, BLK_EMPTY, 1'b0});
    req = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
